md_unit_p: RTL and testbench
============================

# md_unit_p

Parametrised multiply/divide unit for the EX stage. Generalises the fixed 32-bit mult/div unit: operand width is a parameter, multiply latency is configurable, the divider is iterative radix-2, and the unit adds optional accumulate modes (madd/msub), interrupt abort and a divide-by-zero indication. It sits beside the ALU, takes forwarded rs/rt operands, and holds the architectural HI/LO registers that the MEM/WB forwarding paths read.

## Interface

- WIDTH, 32, operand and HI/LO width (≥ 8).
- MUL_LAT, 5, busy cycles for multiply-class ops (≥ 1).
- Clk  in  1  clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  request; sampled only when Busy=0.
- op  in  3  000 mult, 001 multu, 010 div, 011 divu, 100 madd, 101 maddu, 110 msub, 111 msubu.
- D1  in  WIDTH  rs operand; also the mthi/mtlo data.
- D2  in  WIDTH  rt operand.
- IntReq  in  1  interrupt/exception taken; blocks start and aborts an in-flight op.
- mthi, mtlo  in  1  write D1 to HI / LO.
- Busy  out  1  operation in flight.
- done  out  1  one-cycle pulse: HI/LO just committed (or div-by-zero completed).
- dz  out  1  one-cycle pulse with done when a div/divu had D2=0.
- HI, LO  out  WIDTH  architectural registers.

## Operation

- States: IDLE, MUL, DIV, FIX. Reset: IDLE, HI=LO=0, Busy=done=dz=0, counters 0.
- IDLE priority per edge: IntReq (nothing accepted) > mthi/mtlo (write, start ignored) > start.
- Multiply class: operands latched at start; 2·WIDTH product computed (signed for mult/madd/msub, unsigned for u-variants); madd adds / msub subtracts product to/from {HI,LO}, modulo 2^(2·WIDTH), using HI/LO values at commit. MUL counts MUL_LAT cycles then commits {HI,LO}.
- Divide class: magnitudes latched; DIV performs one restoring step per cycle for WIDTH cycles; FIX applies signs for div (quotient toward zero, remainder takes dividend sign) and commits LO=quotient, HI=remainder.
- D2=0: state still traverses DIV/FIX (fixed latency); HI/LO unchanged; dz=1 with done.
- Signed overflow (most-negative ÷ −1): LO=most-negative, HI=0.
- IntReq while Busy: abort; next state IDLE, Busy=0 after that edge, HI/LO unchanged, no done.
- start, mthi, mtlo while Busy: ignored (hazard unit stalls the pipeline).
- Unknown/disabled op (see Configuration): start ignored, stays IDLE.

## Timing

- start accepted at edge T: Busy=1 from T through T+MUL_LAT−1 (multiply) or T+WIDTH (divide; WIDTH DIV + 1 FIX cycles).
- Commit at the edge ending the last busy cycle; HI/LO/done/dz visible in the same cycle Busy returns to 0.
- done and dz are registered, exactly one cycle wide.
- mthi/mtlo: HI/LO updated at the edge where sampled; readable next cycle.
- Busy is registered; start is combinationally decoded only for acceptance.
- Reset asserted mid-operation: immediate IDLE, all outputs 0, no done.

## Configuration

- MD_MADD_EN defined: op 100–111 perform madd/maddu/msub/msubu as above.
- MD_MADD_EN undefined: accumulate logic not built; start with op[2]=1 is ignored (Busy stays 0, HI/LO unchanged, no done).

## Test plan

- WIDTH=32, MUL_LAT=5: mult D1=0xFFFFFFFE (−2), D2=3 -> Busy 5 cycles, HI=0xFFFFFFFF, LO=0xFFFFFFFA, done 1 cycle; multu same operands -> HI=0x2, LO=0xFFFFFFFA.
- div D1=−7 (0xFFFFFFF9), D2=2 -> Busy 33 cycles, LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1); divu D1=7, D2=2 -> LO=3, HI=1.
- divu D2=0 with HI=0x11, LO=0x22 -> after 33 cycles done=dz=1, HI=0x11, LO=0x22; div 0x80000000 ÷ −1 -> LO=0x80000000, HI=0.
- MD_MADD_EN: HI=0, LO=0xFFFFFFFF, maddu D1=1, D2=1 -> HI=1, LO=0; msub D1=2, D2=3 from HI=LO=0 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA. Without macro: same start -> Busy never rises.
- Start div, assert IntReq at cycle 10 -> Busy=0 next cycle, no done, HI/LO unchanged; start with IntReq=1 in IDLE -> not accepted.
- mthi D1=0xABCD with start=1 same edge -> HI=0xABCD, Busy stays 0; async Reset pulse mid-multiply -> HI=LO=0, Busy=0 immediately.

Source files
------------

// File: rtl/md_unit_p_if.sv
// Bus between the EX-stage issue logic and the multiply/divide unit md_unit_p.
// The master drives the request side. The slave (md_unit_p) returns status and HI/LO.
interface md_unit_p_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic             int_req;
  logic             mthi;
  logic             mtlo;
  logic             busy;
  logic             done;
  logic             dz;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, d1, d2, int_req, mthi, mtlo,
    input  busy, done, dz, hi, lo
  );

  modport slave (
    input  start, op, d1, d2, int_req, mthi, mtlo,
    output busy, done, dz, hi, lo
  );
endinterface

// File: rtl/md_unit_p.sv
// md_unit_p: parametrised multiply/divide unit with architectural HI/LO.
// Multiply-class ops take MUL_LAT busy cycles. Divide-class ops take WIDTH radix-2 restoring
// steps plus one sign-fix cycle.
// Optional build macro MD_MADD_EN enables madd/maddu/msub/msubu (op[2]=1). Without it, those
// opcodes are ignored.
// i_srst is a synchronous soft reset with the same effect as rst.
module md_unit_p #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input logic         clk,
  input logic         rst,
  input logic         i_srst,
  md_unit_p_if.slave  bus
);

  localparam int CNT_MAX = (MUL_LAT > WIDTH) ? MUL_LAT : WIDTH;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;
  logic               r_done;
  logic               r_dz;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  // multiply operands and signedness
  logic [WIDTH-1:0]   r_ma;
  logic [WIDTH-1:0]   r_mb;
  logic               r_mul_sgn;
`ifdef MD_MADD_EN
  logic               r_acc;
  logic               r_sub;
`endif
  // divide datapath
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_div0;

  logic               w_op_ok;
  logic               w_sgn;
  logic               w_is_div;
  logic [2*WIDTH-1:0] w_ma;
  logic [2*WIDTH-1:0] w_mb;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_mres;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_diff;
  logic               w_ge;
  logic [WIDTH-1:0]   w_q_fix;
  logic [WIDTH-1:0]   w_r_fix;

  // Absolute value of a signed operand; unsigned operands pass through unchanged.
  // The most negative value maps to itself, and that bit pattern is the correct unsigned
  // magnitude.
  function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v, input logic sgn);
    if (sgn && v[WIDTH-1]) begin
      return ~v + WIDTH'(1);
    end else begin
      return v;
    end
  endfunction

  // Decode the request: op[0] selects unsigned, op[1]&~op[2] selects divide, op[2] selects
  // accumulate.
  always_comb begin
    w_sgn    = ~bus.op[0];
    w_is_div = bus.op[1] & ~bus.op[2];
`ifdef MD_MADD_EN
    w_op_ok  = 1'b1;
`else
    w_op_ok  = ~bus.op[2];
`endif
  end

  // Full-width product of the latched operands, optionally accumulated into {HI,LO}.
  always_comb begin
    if (r_mul_sgn) begin
      w_ma = {{WIDTH{r_ma[WIDTH-1]}}, r_ma};
      w_mb = {{WIDTH{r_mb[WIDTH-1]}}, r_mb};
    end else begin
      w_ma = {{WIDTH{1'b0}}, r_ma};
      w_mb = {{WIDTH{1'b0}}, r_mb};
    end
    w_prod = w_ma * w_mb;
`ifdef MD_MADD_EN
    if (r_acc && r_sub) begin
      w_mres = {r_hi, r_lo} - w_prod;
    end else if (r_acc) begin
      w_mres = {r_hi, r_lo} + w_prod;
    end else begin
      w_mres = w_prod;
    end
`else
    w_mres = w_prod;
`endif
  end

  // One restoring division step, followed by the final sign correction.
  always_comb begin
    w_rem_sh = {r_rem, r_quo[WIDTH-1]};
    w_diff   = w_rem_sh - {1'b0, r_div};
    w_ge     = ~w_diff[WIDTH];
    if (r_neg_q) begin
      w_q_fix = ~r_quo + WIDTH'(1);
    end else begin
      w_q_fix = r_quo;
    end
    if (r_neg_r) begin
      w_r_fix = ~r_rem + WIDTH'(1);
    end else begin
      w_r_fix = r_rem;
    end
  end

  // Control FSM and all architectural/output state.
  // done and dz default low, so each is a one-cycle pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= {CW{1'b0}};
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dz      <= 1'b0;
      r_hi      <= {WIDTH{1'b0}};
      r_lo      <= {WIDTH{1'b0}};
      r_ma      <= {WIDTH{1'b0}};
      r_mb      <= {WIDTH{1'b0}};
      r_mul_sgn <= 1'b0;
`ifdef MD_MADD_EN
      r_acc     <= 1'b0;
      r_sub     <= 1'b0;
`endif
      r_rem     <= {WIDTH{1'b0}};
      r_quo     <= {WIDTH{1'b0}};
      r_div     <= {WIDTH{1'b0}};
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_div0    <= 1'b0;
    end else if (i_srst) begin
      r_state   <= S_IDLE;
      r_cnt     <= {CW{1'b0}};
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dz      <= 1'b0;
      r_hi      <= {WIDTH{1'b0}};
      r_lo      <= {WIDTH{1'b0}};
      r_ma      <= {WIDTH{1'b0}};
      r_mb      <= {WIDTH{1'b0}};
      r_mul_sgn <= 1'b0;
`ifdef MD_MADD_EN
      r_acc     <= 1'b0;
      r_sub     <= 1'b0;
`endif
      r_rem     <= {WIDTH{1'b0}};
      r_quo     <= {WIDTH{1'b0}};
      r_div     <= {WIDTH{1'b0}};
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_div0    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_dz   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.int_req) begin
            r_state <= S_IDLE;
          end else if (bus.mthi || bus.mtlo) begin
            if (bus.mthi) r_hi <= bus.d1;
            if (bus.mtlo) r_lo <= bus.d1;
          end else if (bus.start && w_op_ok) begin
            r_busy <= 1'b1;
            if (w_is_div) begin
              r_state <= S_DIV;
              r_cnt   <= CW'(WIDTH - 1);
              r_rem   <= {WIDTH{1'b0}};
              r_quo   <= f_mag(bus.d1, w_sgn);
              r_div   <= f_mag(bus.d2, w_sgn);
              r_neg_q <= w_sgn & (bus.d1[WIDTH-1] ^ bus.d2[WIDTH-1]);
              r_neg_r <= w_sgn & bus.d1[WIDTH-1];
              r_div0  <= (bus.d2 == {WIDTH{1'b0}});
            end else begin
              r_state   <= S_MUL;
              r_cnt     <= CW'(MUL_LAT - 1);
              r_ma      <= bus.d1;
              r_mb      <= bus.d2;
              r_mul_sgn <= w_sgn;
`ifdef MD_MADD_EN
              r_acc     <= bus.op[2];
              r_sub     <= bus.op[1];
`endif
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_MUL: begin
          if (bus.int_req) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (r_cnt == {CW{1'b0}}) begin
            {r_hi, r_lo} <= w_mres;
            r_done       <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_DIV: begin
          if (bus.int_req) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_rem <= w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], w_ge};
            if (r_cnt == {CW{1'b0}}) begin
              r_state <= S_FIX;
            end else begin
              r_cnt <= r_cnt - CW'(1);
            end
          end
        end
        S_FIX: begin
          if (bus.int_req) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            if (r_div0) begin
              r_dz <= 1'b1;
            end else begin
              r_lo <= w_q_fix;
              r_hi <= w_r_fix;
            end
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.dz   = r_dz;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule

// File: tb/tb_md_unit_p.sv
// Testbench for md_unit_p (WIDTH=32, MUL_LAT=5).
// Expected results come from a 64-bit arithmetic reference model and go into a queue.
// A monitor pops one entry and compares it every time done pulses.
module tb_md_unit_p;
  localparam int W = 32;
  localparam int L = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic srst = 1'b0;
  always #5 clk = ~clk;

  md_unit_p_if #(.WIDTH(W)) bus ();

  md_unit_p #(.WIDTH(W), .MUL_LAT(L)) dut (
    .clk    (clk),
    .rst    (rst),
    .i_srst (srst),
    .bus    (bus.slave)
  );

  int n_vec = 0;
  int n_mis = 0;
  logic [64:0] exp_q[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] req);
    n_vec++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Reference model. Returns {dz, hi, lo} after the op, given HI/LO before it.
  function automatic logic [64:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] hi,
                                            input logic [31:0] lo);
    longint sa, sb, q, r;
    logic [63:0] p, acc;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op[0]) p = {32'd0, a} * {32'd0, b};
    else       p = 64'(sa * sb);
    case (op)
      3'd0, 3'd1: return {1'b0, p};
      3'd2, 3'd3: begin
        if (b == 32'd0) return {1'b1, hi, lo};
        if (op == 3'd2) begin
          q = sa / sb;
          r = sa % sb;
        end else begin
          q = longint'({32'd0, a}) / longint'({32'd0, b});
          r = longint'({32'd0, a}) % longint'({32'd0, b});
        end
        return {1'b0, r[31:0], q[31:0]};
      end
      default: begin
        acc = op[1] ? ({hi, lo} - p) : ({hi, lo} + p);
        return {1'b0, acc};
      end
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [64:0] e;
    if (!rst && bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_mis++;
        $display("FAIL unexpected_done: got done=1 required no pending op");
      end else begin
        e = exp_q.pop_front();
        chk("result_dz_hi_lo", {bus.dz, bus.hi, bus.lo}, e);
      end
    end
  end

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [64:0] e;
    int cyc;
    int lat;
    e   = ref_model(op, a, b, m_hi, m_lo);
    lat = (op[1] && !op[2]) ? (W + 1) : L;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.d1 = a; bus.d2 = b;
    exp_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    chk("busy_cycles", 65'(cyc), 65'(lat));
    m_hi = e[63:32];
    m_lo = e[31:0];
  endtask

  task automatic set_hilo(input logic [31:0] h, input logic [31:0] l);
    @(negedge clk);
    bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.d1 = h;
    @(negedge clk);
    bus.mthi = 1'b0; bus.d1 = l;
    @(negedge clk);
    bus.mtlo = 1'b0;
    m_hi = h;
    m_lo = l;
    chk("mthi_mtlo", {1'b0, bus.hi, bus.lo}, {1'b0, h, l});
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    bus.start = 1'b0; bus.op = 3'd0; bus.d1 = 32'd0; bus.d2 = 32'd0;
    bus.int_req = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state", {bus.busy, bus.done, bus.dz, bus.hi, bus.lo}, 65'd0);
    rst = 1'b0;

    do_op(3'd0, 32'hFFFF_FFFE, 32'd3);
    chk("kat_mult", {1'b0, bus.hi, bus.lo}, {1'b0, 64'hFFFF_FFFF_FFFF_FFFA});
    do_op(3'd1, 32'hFFFF_FFFE, 32'd3);
    chk("kat_multu", {1'b0, bus.hi, bus.lo}, {1'b0, 64'h0000_0002_FFFF_FFFA});
    do_op(3'd2, 32'hFFFF_FFF9, 32'd2);
    chk("kat_div", {1'b0, bus.hi, bus.lo}, {1'b0, 64'hFFFF_FFFF_FFFF_FFFD});
    do_op(3'd3, 32'd7, 32'd2);
    chk("kat_divu", {1'b0, bus.hi, bus.lo}, {1'b0, 64'h0000_0001_0000_0003});
    set_hilo(32'h11, 32'h22);
    do_op(3'd3, 32'd5, 32'd0);
    chk("kat_div0", {1'b0, bus.hi, bus.lo}, {1'b0, 64'h0000_0011_0000_0022});
    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("kat_div_ovf", {1'b0, bus.hi, bus.lo}, {1'b0, 64'h0000_0000_8000_0000});

`ifdef MD_MADD_EN
    set_hilo(32'd0, 32'hFFFF_FFFF);
    do_op(3'd5, 32'd1, 32'd1);
    chk("kat_maddu", {1'b0, bus.hi, bus.lo}, {1'b0, 64'h0000_0001_0000_0000});
    set_hilo(32'd0, 32'd0);
    do_op(3'd6, 32'd2, 32'd3);
    chk("kat_msub", {1'b0, bus.hi, bus.lo}, {1'b0, 64'hFFFF_FFFF_FFFF_FFFA});
`else
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd5; bus.d1 = 32'd1; bus.d2 = 32'd1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("madd_disabled_busy", {64'd0, bus.busy}, 65'd0);
    repeat (L + 1) @(negedge clk);
    chk("madd_disabled_hilo", {1'b0, bus.hi, bus.lo}, {1'b0, m_hi, m_lo});
`endif

    // Interrupt aborts an in-flight divide: no done, HI/LO kept.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd2; bus.d1 = 32'd100; bus.d2 = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    chk("div_busy_before_irq", {64'd0, bus.busy}, 65'd1);
    bus.int_req = 1'b1;
    @(negedge clk);
    bus.int_req = 1'b0;
    chk("irq_abort_busy", {64'd0, bus.busy}, 65'd0);
    repeat (W + 4) @(negedge clk);
    chk("irq_abort_hilo", {1'b0, bus.hi, bus.lo}, {1'b0, m_hi, m_lo});

    // start together with IntReq in IDLE is not accepted.
    bus.start = 1'b1; bus.int_req = 1'b1; bus.op = 3'd1; bus.d1 = 32'd9; bus.d2 = 32'd9;
    @(negedge clk);
    bus.start = 1'b0; bus.int_req = 1'b0;
    chk("irq_blocks_start", {64'd0, bus.busy}, 65'd0);

    // mthi has priority over start on the same edge.
    @(negedge clk);
    bus.mthi = 1'b1; bus.start = 1'b1; bus.op = 3'd0; bus.d1 = 32'hABCD; bus.d2 = 32'd5;
    @(negedge clk);
    bus.mthi = 1'b0; bus.start = 1'b0;
    m_hi = 32'hABCD;
    chk("mthi_over_start", {31'd0, bus.busy, bus.hi}, {33'd0, 32'hABCD});
    repeat (L + 1) @(negedge clk);
    chk("mthi_no_mult", {1'b0, bus.hi, bus.lo}, {1'b0, m_hi, m_lo});

    // Asynchronous reset in the middle of a multiply.
    bus.start = 1'b1; bus.op = 3'd0; bus.d1 = 32'd3; bus.d2 = 32'd4;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_reset_mid_mul", {bus.busy, bus.done, bus.dz, bus.hi, bus.lo}, 65'd0);
    @(negedge clk);
    rst = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    repeat (L + 1) @(negedge clk);
    chk("reset_no_commit", {1'b0, bus.hi, bus.lo}, 65'd0);

    // Synchronous soft reset clears HI/LO.
    set_hilo(32'h55, 32'h66);
    srst = 1'b1;
    @(negedge clk);
    srst = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    chk("soft_reset", {1'b0, bus.hi, bus.lo}, 65'd0);

    // Randomised operations checked against the reference model.
    for (int i = 0; i < 40; i++) begin
`ifdef MD_MADD_EN
      rop = 3'($urandom_range(0, 7));
`else
      rop = 3'($urandom_range(0, 3));
`endif
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 15)) - 32'd8;
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      do_op(rop, ra, rb);
    end

    repeat (5) @(negedge clk);
    chk("queue_drained", 65'(exp_q.size()), 65'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
